// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter sharing one nibble serializer among NREQ requesters.
// Grants one requester, snapshots its nibble, waits for ack or timeout, then idles GAP_CYC cycles.
module serial_link_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int GAP_CYC = 4,
  parameter int TO_CYC  = 255,
  parameter int TO_W    = 8
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 ack,
  output logic [DW-1:0]        Data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  output logic [7:0]           err_cnt
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state, state_n;
  logic [LW-1:0]   last, cur, sel;
  logic [LW-1:0]   ix;
  logic [TO_W-1:0] timer;
  logic            to_hit, gap_end;

  assign to_hit  = (timer == TO_W'(TO_CYC - 1));
  assign gap_end = (timer == TO_W'(GAP_CYC - 1));
  assign busy    = (state != IDLE);

  // Scan downward so the lowest offset from last+1 is the final writer.
  always_comb begin
    sel = '0;
    ix  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      ix = LW'((int'(last) + k) % NREQ);
      if (req[ix]) sel = ix;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|req) state_n = SEND;
      SEND:    if (ack || to_hit) state_n = GAP;
      GAP:     if (gap_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      Data    <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      err_cnt <= '0;
      timer   <= '0;
      last    <= LW'(NREQ - 1);
      cur     <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= NREQ'(1) << sel;
            Data  <= req_data[int'(sel)*DW +: DW];
            cur   <= sel;
            timer <= '0;
          end
        end
        SEND: begin
          // ack takes precedence over a coincident timeout
          if (ack) begin
            done  <= gnt;
            gnt   <= '0;
            last  <= cur;
            timer <= '0;
          end else if (to_hit) begin
            err   <= gnt;
            gnt   <= '0;
            last  <= cur;
            timer <= '0;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (gap_end) timer <= '0;
          else         timer <= timer + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_link_arbiter.sv
// Directed bench for serial_link_arbiter: expected grants are queued when requests are driven
// and popped when the arbiter grants.
module tb_serial_link_arbiter;
  logic        sclk, rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        ack;
  logic [3:0]  Data, gnt, done, err;
  logic        busy;
  logic [7:0]  err_cnt;

  serial_link_arbiter #(.NREQ(4), .DW(4), .GAP_CYC(4), .TO_CYC(255), .TO_W(8)) dut (
    .sclk(sclk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .Data(Data), .gnt(gnt), .done(done), .err(err), .busy(busy), .err_cnt(err_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct { logic [3:0] g; logic [3:0] d; } exp_t;
  exp_t q[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk); #1;
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (gnt == 4'b0 && n < 50) begin tick(); n++; end
    chk({tag, "_gnt_wait"}, 32'(gnt != 4'b0), 1);
  endtask

  task automatic pop_chk(input string tag, output exp_t e);
    chk({tag, "_sb_nonempty"}, 32'(q.size() != 0), 1);
    e = '{4'b0, 4'b0};
    if (q.size() != 0) e = q.pop_front();
    chk({tag, "_gnt"}, gnt, e.g);
    chk({tag, "_data"}, Data, e.d);
    chk({tag, "_busy_send"}, busy, 1);
  endtask

  task automatic gap_chk(input string tag, input logic [3:0] d);
    int cnt;
    cnt = 1;
    tick();
    chk({tag, "_done_1cyc"}, {done, err}, 0);
    while (busy && cnt < 20) begin
      chk({tag, "_gap_gnt"}, gnt, 0);
      cnt++;
      tick();
    end
    chk({tag, "_gap_len"}, cnt, 4);
    chk({tag, "_data_hold"}, Data, d);
  endtask

  // one acknowledged transfer; nreq is applied right after the ack edge
  task automatic xfer(input string tag, input int dly, input logic [3:0] nreq, input bit mangle);
    exp_t e;
    wait_gnt(tag);
    pop_chk(tag, e);
    if (mangle) begin req_data = 16'hFFFF; req = 4'b0; end
    for (int i = 0; i < dly; i++) begin
      if (i == dly - 1) ack = 1'b1;
      tick();
      if (i < dly - 1) chk({tag, "_stable"}, {gnt, Data}, {e.g, e.d});
    end
    ack = 1'b0;
    req = nreq;
    chk({tag, "_done"}, done, e.g);
    chk({tag, "_err0"}, err, 0);
    chk({tag, "_gnt_drop"}, {gnt, 3'b0, busy}, 32'h01);
    gap_chk(tag, e.d);
  endtask

  // one transfer left to time out; nreq is applied once err is seen
  task automatic tmo(input string tag, input logic [3:0] nreq);
    exp_t e;
    int n;
    wait_gnt(tag);
    pop_chk(tag, e);
    n = 0;
    while (err == 4'b0 && n < 300) begin tick(); n++; end
    req = nreq;
    chk({tag, "_to_cycles"}, n, 255);
    chk({tag, "_err"}, err, e.g);
    chk({tag, "_done0"}, done, 0);
    chk({tag, "_gnt_drop"}, gnt, 0);
    gap_chk(tag, e.d);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; req = 4'b1111; req_data = 16'h432A; ack = 1'b0;
    #1 rst = 1'b0;
    // held in reset with requests and a toggling ack
    for (int i = 0; i < 6; i++) begin
      ack = ~ack;
      tick();
      chk("rst_state", {gnt, Data, 3'b0, busy, done, err, err_cnt}, 0);
    end
    ack = 1'b0;
    rst = 1'b1;
    q.push_back('{4'b0001, 4'hA});
    tick();
    chk("rel_gnt", gnt, 4'b0001);
    req = 4'b0001;
    xfer("single", 3, 4'b0000, 1'b0);

    // ack while idle must do nothing
    ack = 1'b1; tick(); ack = 1'b0;
    chk("idle_ack", {gnt, done, err, 3'b0, busy}, 0);

    // bring the pointer to 3 so the round-robin run starts at 0
    req_data = 16'h4321;
    req = 4'b1000;
    q.push_back('{4'b1000, 4'h4});
    xfer("pre", 2, 4'b1111, 1'b0);
    q.push_back('{4'b0001, 4'h1}); q.push_back('{4'b0010, 4'h2});
    q.push_back('{4'b0100, 4'h3}); q.push_back('{4'b1000, 4'h4});
    q.push_back('{4'b0001, 4'h1}); q.push_back('{4'b0010, 4'h2});
    for (int i = 0; i < 6; i++) xfer("rr", 2, (i == 5) ? 4'b0000 : 4'b1111, 1'b0);

    // timeout, then priority moves past the timed-out requester
    req = 4'b0100;
    q.push_back('{4'b0100, 4'h3});
    tmo("to1", 4'b1100);
    chk("to1_cnt", err_cnt, 1);
    q.push_back('{4'b1000, 4'h4}); q.push_back('{4'b0100, 4'h3});
    xfer("after_to3", 2, 4'b1100, 1'b0);
    xfer("after_to2", 2, 4'b0000, 1'b0);

    // ack landing on the timeout cycle
    req = 4'b0001;
    q.push_back('{4'b0001, 4'h1});
    wait_gnt("coll");
    pop_chk("coll", e);
    for (int i = 0; i < 254; i++) tick();
    chk("coll_pre", {gnt, err}, {4'b0001, 4'b0000});
    ack = 1'b1; tick(); ack = 1'b0; req = 4'b0;
    chk("coll_done", done, 4'b0001);
    chk("coll_err", err, 0);
    chk("coll_cnt", err_cnt, 1);
    gap_chk("coll", 4'h1);

    // snapshot: data and request changed mid-transfer
    req = 4'b0010;
    q.push_back('{4'b0010, 4'h2});
    xfer("snap", 3, 4'b0000, 1'b1);
    req_data = 16'h4321;

    // asynchronous reset while requester 1 holds the grant
    req = 4'b0010;
    q.push_back('{4'b0010, 4'h2});
    wait_gnt("mrst");
    pop_chk("mrst", e);
    #2 rst = 1'b0;
    #1 chk("mrst_clear", {gnt, Data, 3'b0, busy, err_cnt}, 0);
    tick();
    chk("mrst_noresp", {done, err, gnt}, 0);
    rst = 1'b1;
    req = 4'b0011;
    q.push_back('{4'b0001, 4'h1});
    xfer("mrst_rel", 2, 4'b0000, 1'b0);

    // saturate the timeout counter
    req = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      q.push_back('{4'b0001, 4'h1});
      tmo("sat", (i == 255) ? 4'b0000 : 4'b0001);
      if (i >= 254) chk("sat_cnt", err_cnt, 8'd255);
    end
    chk("sb_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
